// File: rtl/level_pkg.sv
// -----------------------------------------------------------------------------
// level_pkg
// Shared definitions for the level sequencer: FSM state encodings, the level
// counter width, default parameter values and a helper that sizes the pause
// down-counter from the pause length.
//
// Optional feature macro used by the sequencer: LEVEL_SEQ_LIVES_EN
// -----------------------------------------------------------------------------
package level_pkg;

  localparam int LEVEL_W          = 4;
  localparam int DEF_NUM_LEVELS   = 8;
  localparam int DEF_PAUSE_CYCLES = 100_000_000;
  localparam int DEF_LIVES        = 3;

  // 3-bit state encodings for the game-progress FSM.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_WON   = 3'd3,
    S_LOST  = 3'd4
  } state_t;

  // Counter width able to hold PAUSE_CYCLES-1; never narrower than one bit so
  // a single-cycle pause still yields a legal vector.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage : level_pkg

// File: rtl/level_sequencer_pause_timer.sv
// -----------------------------------------------------------------------------
// pause_timer
// Loadable down-counter that times the inter-level pause. A load sets the
// count to load_val; afterwards it counts down by one per cycle and parks at
// zero. done is high whenever the count is zero.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset, clears the count
//   load      in   load load_val into the counter this cycle
//   load_val  in   [CNT_W-1:0] value to load (PAUSE_CYCLES-1 for a full pause)
//   done      out  count has reached zero
// -----------------------------------------------------------------------------
module pause_timer
  import level_pkg::*;
#(
  parameter int PAUSE_CYCLES = DEF_PAUSE_CYCLES,
  parameter int CNT_W        = cnt_width(PAUSE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule : pause_timer

// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
// Game-progress controller. Owns curr_level for the LED display and level
// datapath, starts a game, advances the level on each completed level with a
// timed pause in between, and flags win (last level cleared) or loss (fail).
//
// Optional feature (macro LEVEL_SEQ_LIVES_EN): a lives counter. A fail with
// more than one life left costs a life and replays the same level after a
// pause; the last life lost ends the game.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   start/restart pulse (acted on in IDLE, WON, LOST)
//   level_done   in   current level cleared pulse (acted on in PLAY)
//   fail         in   player failed pulse (acted on in PLAY, wins over level_done)
//   curr_level   out  [3:0] current level, 1..NUM_LEVELS
//   level_start  out  one-cycle pulse on each entry to PLAY
//   in_play      out  high while in PLAY
//   game_won     out  high while in WON
//   game_over    out  high while in LOST
//   lives_left   out  [3:0] remaining lives (only with LEVEL_SEQ_LIVES_EN)
// -----------------------------------------------------------------------------
module level_sequencer
  import level_pkg::*;
#(
  parameter int NUM_LEVELS   = DEF_NUM_LEVELS,
  parameter int PAUSE_CYCLES = DEF_PAUSE_CYCLES
`ifdef LEVEL_SEQ_LIVES_EN
  ,
  parameter int LIVES        = DEF_LIVES
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               level_done,
  input  logic               fail,
  output logic [LEVEL_W-1:0] curr_level,
  output logic               level_start,
  output logic               in_play,
  output logic               game_won,
  output logic               game_over
`ifdef LEVEL_SEQ_LIVES_EN
  ,
  output logic [LEVEL_W-1:0] lives_left
`endif
);

  localparam int                 CNT_W      = cnt_width(PAUSE_CYCLES);
  localparam logic [CNT_W-1:0]   PAUSE_LOAD = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS);
  localparam logic [LEVEL_W-1:0] FIRST_LVL  = LEVEL_W'(1);
`ifdef LEVEL_SEQ_LIVES_EN
  localparam logic [LEVEL_W-1:0] FULL_LIVES = LEVEL_W'(LIVES);
`endif

  state_t state;
  logic   pause_load;
  logic   pause_done;

  // ---------------------------------------------------------------------------
  // Pause timer load: every PLAY -> PAUSE transition restarts a full pause.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pause_load = 1'b0;
    if (state == S_PLAY) begin
      if (fail) begin
`ifdef LEVEL_SEQ_LIVES_EN
        // A survivable fail retries the level after a pause.
        pause_load = (lives_left > FIRST_LVL);
`endif
      end else if (level_done && (curr_level != LAST_LEVEL)) begin
        pause_load = 1'b1;
      end
    end
  end

  pause_timer #(
    .PAUSE_CYCLES (PAUSE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_pause_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (pause_load),
    .load_val (PAUSE_LOAD),
    .done     (pause_done)
  );

  // ---------------------------------------------------------------------------
  // Game FSM with registered outputs. The timer holds PAUSE_CYCLES-1 on the
  // first PAUSE cycle and the exit fires on the cycle it reads zero, so PAUSE
  // lasts exactly PAUSE_CYCLES cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      curr_level  <= FIRST_LVL;
      level_start <= 1'b0;
      in_play     <= 1'b0;
      game_won    <= 1'b0;
      game_over   <= 1'b0;
`ifdef LEVEL_SEQ_LIVES_EN
      lives_left  <= FULL_LIVES;
`endif
    end else begin
      // level_start is a pulse: only the entering edge raises it.
      level_start <= 1'b0;

      case (state)
        // Flags are already clear in IDLE, so one entry path serves all three.
        S_IDLE, S_WON, S_LOST: begin
          if (start) begin
            state       <= S_PLAY;
            curr_level  <= FIRST_LVL;
            level_start <= 1'b1;
            in_play     <= 1'b1;
            game_won    <= 1'b0;
            game_over   <= 1'b0;
`ifdef LEVEL_SEQ_LIVES_EN
            lives_left  <= FULL_LIVES;
`endif
          end
        end

        S_PLAY: begin
          if (fail) begin
            in_play <= 1'b0;
`ifdef LEVEL_SEQ_LIVES_EN
            if (lives_left > FIRST_LVL) begin
              // Retry: curr_level is left untouched.
              lives_left <= lives_left - LEVEL_W'(1);
              state      <= S_PAUSE;
            end else begin
              lives_left <= '0;
              state      <= S_LOST;
              game_over  <= 1'b1;
            end
`else
            state     <= S_LOST;
            game_over <= 1'b1;
`endif
          end else if (level_done) begin
            in_play <= 1'b0;
            if (curr_level == LAST_LEVEL) begin
              state    <= S_WON;
              game_won <= 1'b1;
            end else begin
              // Bumped on this edge so the display shows the new level
              // throughout the pause; bounded by LAST_LEVEL, so no wrap.
              state      <= S_PAUSE;
              curr_level <= curr_level + LEVEL_W'(1);
            end
          end
        end

        S_PAUSE: begin
          if (pause_done) begin
            state       <= S_PLAY;
            level_start <= 1'b1;
            in_play     <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : level_sequencer

// File: tb/tb_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_level_sequencer
// Directed bench for level_sequencer with NUM_LEVELS=3, PAUSE_CYCLES=4
// (LIVES=2 when LEVEL_SEQ_LIVES_EN is defined). Inputs change 1 ns after the
// rising edge; outputs are sampled at the same point, i.e. they reflect the
// edge just taken.
// -----------------------------------------------------------------------------
module tb_level_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       level_done;
  logic       fail;
  logic [3:0] curr_level;
  logic       level_start;
  logic       in_play;
  logic       game_won;
  logic       game_over;
`ifdef LEVEL_SEQ_LIVES_EN
  logic [3:0] lives_left;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  level_sequencer #(
    .NUM_LEVELS   (3),
    .PAUSE_CYCLES (4)
`ifdef LEVEL_SEQ_LIVES_EN
    ,
    .LIVES        (2)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .level_done  (level_done),
    .fail        (fail),
    .curr_level  (curr_level),
    .level_start (level_start),
    .in_play     (in_play),
    .game_won    (game_won),
    .game_over   (game_over)
`ifdef LEVEL_SEQ_LIVES_EN
    ,
    .lives_left  (lives_left)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int lvl, input bit ls,
                            input bit ip, input bit gw, input bit go);
    check({tag, ".curr_level"},  32'(curr_level),  32'(lvl));
    check({tag, ".level_start"}, 32'(level_start), 32'(ls));
    check({tag, ".in_play"},     32'(in_play),     32'(ip));
    check({tag, ".game_won"},    32'(game_won),    32'(gw));
    check({tag, ".game_over"},   32'(game_over),   32'(go));
  endtask

  // Called on the first PAUSE cycle. Checks all four pause cycles and takes
  // the edge back into PLAY. With inject set, start/level_done/fail are all
  // pulsed on the second pause cycle and must have no effect.
  task automatic wait_pause(input string tag, input int lvl, input bit inject);
    for (int i = 0; i < 4; i++) begin
      check_outs($sformatf("%s.pause%0d", tag, i), lvl, 1'b0, 1'b0, 1'b0, 1'b0);
      if (inject && i == 1) begin
        start      = 1'b1;
        level_done = 1'b1;
        fail       = 1'b1;
      end
      tick();
      start      = 1'b0;
      level_done = 1'b0;
      fail       = 1'b0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    level_done = 1'b0;
    fail       = 1'b0;
    tick();
    tick();
    check_outs("reset", 1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef LEVEL_SEQ_LIVES_EN
    check("reset.lives_left", 32'(lives_left), 32'd2);
`endif
    rst = 1'b0;

    // Idle, with level_done/fail ignored, then start.
    level_done = 1'b1;
    fail       = 1'b1;
    tick();
    level_done = 1'b0;
    fail       = 1'b0;
    tick();
    check_outs("idle", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("start", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("play1", 1, 1'b0, 1'b1, 1'b0, 1'b0);

    // start is ignored in PLAY.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("play1_start_ignored", 1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Level 1 cleared -> pause at level 2 with stray pulses -> play level 2.
    level_done = 1'b1;
    tick();
    level_done = 1'b0;
    wait_pause("l1_done", 2, 1'b1);
    check_outs("play2_entry", 2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_outs("play2", 2, 1'b0, 1'b1, 1'b0, 1'b0);

    // Level 2 cleared -> pause -> play level 3.
    level_done = 1'b1;
    tick();
    level_done = 1'b0;
    wait_pause("l2_done", 3, 1'b0);
    check_outs("play3_entry", 3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Last level cleared -> WON, level holds, no level_start.
    level_done = 1'b1;
    tick();
    level_done = 1'b0;
    check_outs("won", 3, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_outs("won_hold", 3, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart from WON.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("restart_won", 1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // Reach level 2 again.
    level_done = 1'b1;
    tick();
    level_done = 1'b0;
    wait_pause("g2_l1_done", 2, 1'b0);
    check_outs("g2_play2_entry", 2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    // fail and level_done together: fail wins.
    fail       = 1'b1;
    level_done = 1'b1;
    tick();
    fail       = 1'b0;
    level_done = 1'b0;
`ifdef LEVEL_SEQ_LIVES_EN
    check_outs("fail1_retry", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fail1.lives_left", 32'(lives_left), 32'd1);
    wait_pause("fail1", 2, 1'b0);
    check_outs("retry_entry", 2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    fail = 1'b1;
    tick();
    fail = 1'b0;
    check_outs("fail2_lost", 2, 1'b0, 1'b0, 1'b0, 1'b1);
    check("fail2.lives_left", 32'(lives_left), 32'd0);
`else
    check_outs("lost", 2, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    tick();
    check_outs("lost_hold", 2, 1'b0, 1'b0, 1'b0, 1'b1);

    // Restart from LOST.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("restart_lost", 1, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef LEVEL_SEQ_LIVES_EN
    check("restart.lives_left", 32'(lives_left), 32'd2);
`endif
    tick();

    // Reset on the 2nd pause cycle.
    level_done = 1'b1;
    tick();
    level_done = 1'b0;
    check_outs("pre_rst_pause0", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outs("mid_pause_rst", 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back in IDLE: level_done ignored, start accepted.
    level_done = 1'b1;
    tick();
    level_done = 1'b0;
    check_outs("post_rst_idle", 1, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_outs("post_rst_start", 1, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_level_sequencer
